eth_miim_sequencer: RTL and testbench
=====================================

// Module: eth_miim_sequencer
// PURPOSE
//   Sequences one IEEE 802.3 clause-22 MDIO management frame (write or read) using the MdcEn/MdcEn_n
//   strobes from the MDC clock generator. Drives Mdo/MdoEn toward the pad, samples Mdi and returns
//   read data. Sits between the host register block and the MDIO pad.
// PARAMETERS
//   PRE_LEN   32  preamble length in MDC bits (all ones); skipped when NoPre=1
//   DATA_W    16  management data width (fixed by standard; parameter for reuse only)
// PORTS
//   Clk        in   1       host clock; all logic on posedge
//   Reset_n    in   1       asynchronous, active-low reset
//   MdcEn      in   1       1-Clk strobe, asserted the Clk before Mdc rises (sample point)
//   MdcEn_n    in   1       1-Clk strobe, asserted the Clk before Mdc falls (drive point)
//   NoPre      in   1       1 = omit preamble; sampled at command accept
//   WCtrlData  in   1       write command pulse
//   RStat      in   1       read command pulse
//   Fiad       in   5       PHY address
//   Rgad       in   5       register address
//   CtrlData   in   16      write data
//   Mdi        in   1       MDIO input (synchronised upstream)
//   Mdo        out  1       MDIO output data
//   MdoEn      out  1       MDIO output enable (1 = drive pad)
//   Busy       out  1       frame in progress
//   Done       out  1       1-Clk pulse at frame end
//   Prsd       out  16      last read data
// BEHAVIOUR
//   Reset: Mdo=0, MdoEn=0, Busy=0, Done=0, Prsd=16'h0000, state IDLE, bit counter 0.
//   Accept: only in IDLE. WCtrlData and RStat same cycle -> write wins, read dropped. Pulses while Busy
//     ignored. On accept latch Fiad, Rgad, CtrlData, NoPre, op; Busy=1 from next Clk.
//   Drive: each frame bit is loaded into Mdo (MdoEn=1) at the end of a MdcEn_n cycle, so Mdo changes
//     with Mdc fall and is stable at Mdc rise. First bit on the first MdcEn_n after accept.
//   Sample: Mdi captured in MdcEn cycles during read DATA phase only, MSB first.
//   Frame bits (MSB first): PRE 32x'1 | ST 01 | OP 01=write,10=read | PHYAD 5 | REGAD 5 | TA | DATA 16.
//     Write TA = 10 driven; read TA: MdoEn=0 for both TA bits and all DATA bits.
//   FSM (advance only on MdcEn_n, bit counter 6-bit, reloaded per state):
//     IDLE -accept-> PRE (or CMD if NoPre) ; PRE -PRE_LEN bits-> CMD ; CMD -14 bits-> TA ;
//     TA -2 bits-> DATA ; DATA -16 bits-> FIN ; FIN -next MdcEn_n-> IDLE.
//   FIN: on its MdcEn_n cycle MdoEn=0, Mdo=0; Done=1 for that one Clk; Busy=0 on the following Clk.
//     Read: Prsd updated with the 16 sampled bits in the same cycle Done asserts. Write: Prsd unchanged.
//   Frame length: 64 MDC periods (32 with NoPre); Busy spans frame + up to one MDC period startup.
//   MdcEn and MdcEn_n never both high (generator guarantee); bench asserts it; RTL gives MdcEn_n priority.
//   Reset_n low mid-frame: immediate return to reset values, no Done pulse, Prsd cleared.
//   Input changes on Fiad/Rgad/CtrlData/NoPre while Busy have no effect on the current frame.
// STRUCTURE
//   eth_miim_pkg: state enum (IDLE,PRE,CMD,TA,DATA,FIN), OP_WRITE=2'b01, OP_READ=2'b10, ST=2'b01,
//     CMD_BITS=14, TA_BITS=2, DATA_BITS=16.
//   Sub-module eth_miim_shreg: 16-bit parallel-load/serial-out + serial-in shifter (MSB first),
//     enables from sequencer; sequencer holds FSM, counter and command latches.
// TESTING
//   1 Write, NoPre=0, Fiad=5'h01, Rgad=5'h04, CtrlData=16'hA5C3 -> Mdo bits 32x1,01,01,00001,00100,10,
//     A5C3; MdoEn=1 throughout; one Done; Prsd stays 0000.
//   2 Read, NoPre=1, Fiad=5'h1F, Rgad=5'h02, PHY model returns 16'h0141 -> 14 cmd bits driven, MdoEn=0
//     for TA+DATA, Prsd=16'h0141 in Done cycle, frame = 32 MDC periods.
//   3 WCtrlData and RStat in same Clk -> write frame only (OP=01), exactly one Done.
//   4 RStat pulsed mid-write frame -> ignored; no second frame; Busy drops after single Done.
//   5 Reset_n low at bit 40 of a read -> Mdo=0, MdoEn=0, Busy=0, Prsd=0000 immediately; no Done; next
//     write after release produces a clean full frame.
//   6 Change CtrlData 16'h1234->16'hFFFF during a write -> frame carries 1234.

Source files
------------

// File: rtl/eth_miim_pkg.sv
// Shared types and constants for the clause-22 MDIO frame sequencer.
package eth_miim_pkg;

  typedef enum logic [2:0] {IDLE, PRE, CMD, TA, DATA, FIN} state_t;

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] ST       = 2'b01;
  localparam logic [1:0] TA_WRITE = 2'b10;

  localparam int CMD_BITS  = 14;
  localparam int TA_BITS   = 2;
  localparam int DATA_BITS = 16;

endpackage

// File: rtl/eth_miim_shreg.sv
// Management data shifter: parallel load of write data, MSB-first shift for both
// serialising write data and collecting read data.
module eth_miim_shreg #(
  parameter int W = 16
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_data,
  input  logic         i_shift,
  input  logic         i_sin,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_load_data;
    end else if (i_shift) begin
      r_q <= {r_q[W-2:0], i_sin};
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/eth_miim_sequencer.sv
// Clause-22 MDIO frame sequencer: drives one write or read frame bit-by-bit on the
// MdcEn_n strobes and captures read data on the MdcEn strobes.
module eth_miim_sequencer
  import eth_miim_pkg::*;
#(
  parameter int PRE_LEN = 32,
  parameter int DATA_W  = DATA_BITS
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              MdcEn,
  input  logic              MdcEn_n,
  input  logic              NoPre,
  input  logic              WCtrlData,
  input  logic              RStat,
  input  logic [4:0]        Fiad,
  input  logic [4:0]        Rgad,
  input  logic [DATA_W-1:0] CtrlData,
  input  logic              Mdi,
  output logic              Mdo,
  output logic              MdoEn,
  output logic              Busy,
  output logic              Done,
  output logic [DATA_W-1:0] Prsd
);

  localparam logic [5:0] PRE_LAST  = 6'(PRE_LEN - 1);
  localparam logic [5:0] CMD_LAST  = 6'(CMD_BITS - 1);
  localparam logic [5:0] TA_LAST   = 6'(TA_BITS - 1);
  localparam logic [5:0] DATA_LAST = 6'(DATA_W - 1);

  state_t              r_state, w_state_nxt;
  logic [5:0]          r_cnt, w_cnt_nxt;
  logic [4:0]          r_fiad, r_rgad;
  logic [1:0]          r_op;
  logic                r_busy, r_done, r_mdo, r_mdoen;
  logic [DATA_W-1:0]   r_prsd;
  logic                w_mdo_nxt, w_mdoen_nxt, w_done_nxt;
  logic                w_shift_out, w_sample, w_accept, w_is_read;
  logic [CMD_BITS-1:0] w_cmd;
  logic [3:0]          w_cmd_idx;
  logic [DATA_W-1:0]   w_sh_q;

  assign w_accept  = (r_state == IDLE) && !r_busy && (WCtrlData || RStat);
  assign w_is_read = (r_op == OP_READ);
  assign w_cmd     = {ST, r_op, r_fiad, r_rgad};
  assign w_cmd_idx = 4'(CMD_BITS - 1) - r_cnt[3:0];

  // Mdc rises one bit behind the drive point, so the last data bit is sampled in FIN
  // and the rise in DATA with count 0 still belongs to the second TA bit.
  assign w_sample = MdcEn && !MdcEn_n && w_is_read &&
                    (((r_state == DATA) && (r_cnt != 6'd0)) || (r_state == FIN));

  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_mdo_nxt   = r_mdo;
    w_mdoen_nxt = r_mdoen;
    w_done_nxt  = 1'b0;
    w_shift_out = 1'b0;
    case (r_state)
      IDLE: if (w_accept) begin
        w_state_nxt = NoPre ? CMD : PRE;
        w_cnt_nxt   = '0;
      end
      PRE: if (MdcEn_n) begin
        w_mdo_nxt   = 1'b1;
        w_mdoen_nxt = 1'b1;
        if (r_cnt == PRE_LAST) begin
          w_state_nxt = CMD;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 6'd1;
        end
      end
      CMD: if (MdcEn_n) begin
        w_mdo_nxt   = w_cmd[w_cmd_idx];
        w_mdoen_nxt = 1'b1;
        if (r_cnt == CMD_LAST) begin
          w_state_nxt = TA;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 6'd1;
        end
      end
      TA: if (MdcEn_n) begin
        w_mdo_nxt   = !w_is_read && (r_cnt[0] ? TA_WRITE[0] : TA_WRITE[1]);
        w_mdoen_nxt = !w_is_read;
        if (r_cnt == TA_LAST) begin
          w_state_nxt = DATA;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 6'd1;
        end
      end
      DATA: if (MdcEn_n) begin
        w_mdo_nxt   = !w_is_read && w_sh_q[DATA_W-1];
        w_mdoen_nxt = !w_is_read;
        w_shift_out = !w_is_read;
        if (r_cnt == DATA_LAST) begin
          w_state_nxt = FIN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 6'd1;
        end
      end
      FIN: if (MdcEn_n) begin
        w_mdo_nxt   = 1'b0;
        w_mdoen_nxt = 1'b0;
        w_done_nxt  = 1'b1;
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_fiad  <= '0;
      r_rgad  <= '0;
      r_op    <= OP_WRITE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_mdo   <= 1'b0;
      r_mdoen <= 1'b0;
      r_prsd  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_mdo   <= w_mdo_nxt;
      r_mdoen <= w_mdoen_nxt;
      r_done  <= w_done_nxt;
      if (w_accept) begin
        r_fiad <= Fiad;
        r_rgad <= Rgad;
        r_op   <= WCtrlData ? OP_WRITE : OP_READ;
        r_busy <= 1'b1;
      end else if (r_done) begin
        r_busy <= 1'b0;
      end
      if (w_done_nxt && w_is_read) begin
        r_prsd <= w_sh_q;
      end
    end
  end

  eth_miim_shreg #(.W(DATA_W)) u_shreg (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .i_load      (w_accept),
    .i_load_data (CtrlData),
    .i_shift     (w_shift_out || w_sample),
    .i_sin       (w_is_read && Mdi),
    .o_q         (w_sh_q)
  );

  assign Mdo   = r_mdo;
  assign MdoEn = r_mdoen;
  assign Busy  = r_busy;
  assign Done  = r_done;
  assign Prsd  = r_prsd;

endmodule

// File: tb/tb_eth_miim_sequencer.sv
// Bench for eth_miim_sequencer: MDC strobe generator, bit-level frame monitor with a
// PHY read-data model, table of frames plus hand-written corner sequences.
module tb_eth_miim_sequencer;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        MdcEn = 1'b0;
  logic        MdcEn_n = 1'b0;
  logic        NoPre = 1'b0;
  logic        WCtrlData = 1'b0;
  logic        RStat = 1'b0;
  logic [4:0]  Fiad = '0;
  logic [4:0]  Rgad = '0;
  logic [15:0] CtrlData = '0;
  logic        Mdi = 1'b0;
  logic        Mdo, MdoEn, Busy, Done;
  logic [15:0] Prsd;

  int total = 0;
  int bad = 0;

  int          ph = 0;
  int          done_cnt = 0;
  logic [15:0] prsd_at_done = '0;
  logic        busy_at_done = 1'b0;
  bit          started = 1'b0;
  int          off = 0;
  logic [15:0] phy_data = '0;
  bit          q_mdo[$];
  bit          q_en[$];

  typedef struct packed {
    logic        wr;
    logic        rd;
    logic        nopre;
    logic [4:0]  fiad;
    logic [4:0]  rgad;
    logic [15:0] data;
    logic [15:0] phy;
    logic [15:0] exp_prsd;
  } vec_t;

  vec_t vecs[6];

  eth_miim_sequencer dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .MdcEn     (MdcEn),
    .MdcEn_n   (MdcEn_n),
    .NoPre     (NoPre),
    .WCtrlData (WCtrlData),
    .RStat     (RStat),
    .Fiad      (Fiad),
    .Rgad      (Rgad),
    .CtrlData  (CtrlData),
    .Mdi       (Mdi),
    .Mdo       (Mdo),
    .MdoEn     (MdoEn),
    .Busy      (Busy),
    .Done      (Done),
    .Prsd      (Prsd)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) assert (!(MdcEn && MdcEn_n));

  // MDC period of 8 Clk; records each bit on the wire at its Mdc rise and plays the PHY.
  always @(negedge Clk) begin
    ph      = (ph == 7) ? 0 : ph + 1;
    MdcEn_n = (ph == 0);
    MdcEn   = (ph == 4);
    if (Done) begin
      done_cnt++;
      prsd_at_done = Prsd;
      busy_at_done = Busy;
    end
    if (!Busy) begin
      started = 1'b0;
      off     = 0;
    end else if (MdcEn && (MdoEn || started)) begin
      started = 1'b1;
      q_mdo.push_back(Mdo);
      q_en.push_back(MdoEn);
      if (!MdoEn) begin
        Mdi = (off >= 2 && off < 18) ? phy_data[17 - off] : 1'b0;
        off++;
      end
    end
  end

  task automatic tick();
    @(negedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic exp_frame(input logic wr, input logic np, input logic [4:0] fa,
                           input logic [4:0] ra, input logic [15:0] d,
                           output logic [63:0] m, output logic [63:0] e, output int len);
    logic [13:0] cmd;
    cmd = {2'b01, (wr ? 2'b01 : 2'b10), fa, ra};
    m   = {32'hFFFF_FFFF, cmd, (wr ? 2'b10 : 2'b00), (wr ? d : 16'h0000)};
    e   = {32'hFFFF_FFFF, 14'h3FFF, (wr ? 18'h3FFFF : 18'h00000)};
    len = np ? 32 : 64;
    if (np) begin
      m = {32'h0, m[31:0]};
      e = {32'h0, e[31:0]};
    end
  endtask

  task automatic start_cmd(input logic wr, input logic rd, input logic np,
                           input logic [4:0] fa, input logic [4:0] ra, input logic [15:0] d);
    NoPre = np; Fiad = fa; Rgad = ra; CtrlData = d;
    WCtrlData = wr; RStat = rd;
    tick();
    WCtrlData = 1'b0; RStat = 1'b0;
  endtask

  task automatic finish_frame(input string nm, input int base, input int bd,
                              input logic wr, input logic np, input logic [4:0] fa,
                              input logic [4:0] ra, input logic [15:0] d,
                              input logic [15:0] exp_prsd);
    logic [63:0] em, ee, gm, ge;
    int elen, glen, n;
    n = 0;
    while (done_cnt == bd && n < 3000) begin
      tick();
      n++;
    end
    check({nm, "_done_seen"}, 64'(done_cnt > bd), 64'd1);
    check({nm, "_busy_in_done"}, 64'(busy_at_done), 64'd1);
    check({nm, "_prsd_at_done"}, 64'(prsd_at_done), 64'(exp_prsd));
    tick();
    check({nm, "_busy_drop"}, 64'(Busy), 64'd0);
    repeat (10) tick();
    check({nm, "_done_count"}, 64'(done_cnt - bd), 64'd1);
    exp_frame(wr, np, fa, ra, d, em, ee, elen);
    glen = q_mdo.size() - base;
    check({nm, "_frame_len"}, 64'(glen), 64'(elen));
    gm = '0; ge = '0;
    for (int i = 0; i < glen && i < 64; i++) begin
      gm = {gm[62:0], q_mdo[base + i]};
      ge = {ge[62:0], q_en[base + i]};
    end
    check({nm, "_mdoen_bits"}, ge, ee);
    check({nm, "_mdo_bits"}, gm & ee, em & ee);
  endtask

  initial begin
    int base, bd, n;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 5'h01, 5'h04, 16'hA5C3, 16'h0000, 16'h0000};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 5'h1F, 5'h02, 16'h0000, 16'h0141, 16'h0141};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 5'h00, 5'h1F, 16'h0001, 16'h0000, 16'h0141};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 5'h0A, 5'h15, 16'h0000, 16'h8001, 16'h8001};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 5'h12, 5'h0C, 16'h5A5A, 16'h0000, 16'h8001};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 5'h03, 5'h07, 16'h0000, 16'hFFFF, 16'hFFFF};

    repeat (3) tick();
    check("reset_mdo", 64'(Mdo), 64'd0);
    check("reset_mdoen", 64'(MdoEn), 64'd0);
    check("reset_busy", 64'(Busy), 64'd0);
    check("reset_done", 64'(Done), 64'd0);
    check("reset_prsd", 64'(Prsd), 64'd0);
    Reset_n = 1'b1;
    repeat (5) tick();

    for (int v = 0; v < 6; v++) begin
      phy_data = vecs[v].phy;
      base = q_mdo.size();
      bd   = done_cnt;
      start_cmd(vecs[v].wr, vecs[v].rd, vecs[v].nopre, vecs[v].fiad, vecs[v].rgad, vecs[v].data);
      finish_frame($sformatf("vec%0d", v), base, bd, vecs[v].wr || !vecs[v].rd, vecs[v].nopre,
                   vecs[v].fiad, vecs[v].rgad, vecs[v].data, vecs[v].exp_prsd);
      repeat (3) tick();
    end

    // Read request arriving mid-write must be dropped entirely.
    base = q_mdo.size();
    bd   = done_cnt;
    start_cmd(1'b1, 1'b0, 1'b0, 5'h02, 5'h03, 16'h0F0F);
    repeat (100) tick();
    RStat = 1'b1;
    tick();
    RStat = 1'b0;
    finish_frame("rstat_mid", base, bd, 1'b1, 1'b0, 5'h02, 5'h03, 16'h0F0F, 16'hFFFF);
    repeat (200) tick();
    check("rstat_mid_no_second", 64'(done_cnt - bd), 64'd1);
    check("rstat_mid_idle", 64'(Busy), 64'd0);
    check("rstat_mid_no_bits", 64'(q_mdo.size() - base), 64'd64);

    // Command inputs changing while Busy do not reach the frame.
    base = q_mdo.size();
    bd   = done_cnt;
    start_cmd(1'b1, 1'b0, 1'b1, 5'h06, 5'h11, 16'h1234);
    repeat (20) tick();
    CtrlData = 16'hFFFF; Fiad = 5'h1F; Rgad = 5'h00; NoPre = 1'b0;
    finish_frame("data_hold", base, bd, 1'b1, 1'b1, 5'h06, 5'h11, 16'h1234, 16'hFFFF);

    // Reset at bit 40 of a read frame.
    phy_data = 16'hBEEF;
    base = q_mdo.size();
    bd   = done_cnt;
    start_cmd(1'b0, 1'b1, 1'b0, 5'h09, 5'h0E, 16'h0000);
    n = 0;
    while ((q_mdo.size() - base) < 40 && n < 3000) begin
      tick();
      n++;
    end
    check("rst_mid_reached_bit40", 64'((q_mdo.size() - base) >= 40), 64'd1);
    Reset_n = 1'b0;
    #1;
    check("rst_mid_mdo", 64'(Mdo), 64'd0);
    check("rst_mid_mdoen", 64'(MdoEn), 64'd0);
    check("rst_mid_busy", 64'(Busy), 64'd0);
    check("rst_mid_prsd", 64'(Prsd), 64'd0);
    repeat (20) tick();
    check("rst_mid_no_done", 64'(done_cnt - bd), 64'd0);
    Reset_n = 1'b1;
    repeat (3) tick();
    base = q_mdo.size();
    bd   = done_cnt;
    start_cmd(1'b1, 1'b0, 1'b0, 5'h05, 5'h09, 16'hC0DE);
    finish_frame("post_rst", base, bd, 1'b1, 1'b0, 5'h05, 5'h09, 16'hC0DE, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
